// File: rtl/rx_ber_pkg.sv
// Shared constants and FSM encoding for the receive-side BER checker.
package rx_ber_pkg;

    localparam int OS_FACTOR = 4;
    localparam int NB_PHASE  = $clog2(OS_FACTOR);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/rx_ber_checker_if.sv
// Oversampled filter-output stream plus the baud-rate local PRBS reference stream.
interface rx_ber_checker_if #(
    parameter int NB_INPUT = 8
) ();

    logic                       valid;
    logic signed [NB_INPUT-1:0] sample;
    logic                       ref_valid;
    logic                       ref_bit;

    modport master (output valid, sample, ref_valid, ref_bit);
    modport slave  (input  valid, sample, ref_valid, ref_bit);

endinterface

// File: rtl/rx_ref_delay_line.sv
// Reference bit history with a delay-indexed tap; the tap reads pre-shift contents.
module rx_ref_delay_line #(
    parameter int NB_DELAY = 9
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_shift,
    input  logic                i_bit,
    input  logic [NB_DELAY-1:0] i_delay,
    output logic                o_ref_bit
);

    localparam int DEPTH = 2 ** NB_DELAY;

    logic [DEPTH-1:0] line_q;
    logic [DEPTH-1:0] line_d;

    always_comb begin
        line_d = line_q;
        if (i_shift) begin
            line_d = {line_q[DEPTH-2:0], i_bit};
        end
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            line_q <= '0;
        end else if (i_enable) begin
            line_q <= line_d;
        end
    end

    assign o_ref_bit = line_q[i_delay];

endmodule

// File: rtl/rx_ber_checker.sv
// Decimates the 4x BPSK stream, slices the sign, searches the reference latency with
// the fewest errors, then accumulates bit and error counts while locked.
module rx_ber_checker
    import rx_ber_pkg::*;
#(
    parameter int NB_INPUT = 8,
    parameter int NB_DELAY = 9,
    parameter int NB_WIN   = 9,
    parameter int NB_CNT   = 64
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_enable,
    rx_ber_checker_if.slave     s_if,
    input  logic [NB_PHASE-1:0] i_phase_sel,
    input  logic                i_resync,
    output logic                o_rx_bit,
    output logic                o_rx_valid,
    output logic                o_locked,
    output logic [NB_DELAY-1:0] o_delay,
    output logic [NB_CNT-1:0]   o_bit_count,
    output logic [NB_CNT-1:0]   o_err_count
);

    localparam logic signed [NB_INPUT-1:0] ZERO = '0;

    state_t              state_q, state_d;
    logic [NB_PHASE-1:0] phase_q, phase_d;
    logic                rx_bit_q, rx_bit_d;
    logic                rx_valid_q, rx_valid_d;
    logic [NB_DELAY-1:0] fill_cnt_q, fill_cnt_d;
    logic [NB_DELAY-1:0] delay_q, delay_d;
    logic [NB_DELAY-1:0] best_delay_q, best_delay_d;
    logic [NB_WIN:0]     best_err_q, best_err_d;
    logic [NB_WIN:0]     win_err_q, win_err_d;
    logic [NB_WIN-1:0]   win_cnt_q, win_cnt_d;
    logic [NB_CNT-1:0]   bit_cnt_q, bit_cnt_d;
    logic [NB_CNT-1:0]   err_cnt_q, err_cnt_d;

    logic            strobe;
    logic            slice_bit;
    logic            ref_tap;
    logic            err_bit;
    logic [NB_WIN:0] win_err_sum;
    logic            win_better;

    rx_ref_delay_line #(
        .NB_DELAY (NB_DELAY)
    ) u_ref_line (
        .clock     (clock),
        .i_reset   (i_reset),
        .i_enable  (i_enable),
        .i_shift   (s_if.ref_valid),
        .i_bit     (s_if.ref_bit),
        .i_delay   (delay_q),
        .o_ref_bit (ref_tap)
    );

    // Negative samples slice to 1, matching the TX mapping of 1 to a negated pulse.
    always_comb begin
        strobe      = s_if.valid && (phase_q == i_phase_sel);
        slice_bit   = (s_if.sample < ZERO);
        err_bit     = slice_bit ^ ref_tap;
        phase_d     = s_if.valid ? phase_q + 1'b1 : phase_q;
        rx_valid_d  = strobe;
        rx_bit_d    = strobe ? slice_bit : rx_bit_q;
        win_err_sum = win_err_q + {{NB_WIN{1'b0}}, err_bit};
        win_better  = (win_err_sum < best_err_q);
    end

    always_comb begin
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        delay_d      = delay_q;
        best_delay_d = best_delay_q;
        best_err_d   = best_err_q;
        win_err_d    = win_err_q;
        win_cnt_d    = win_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        err_cnt_d    = err_cnt_q;

        if (i_resync && (state_q != ST_FILL)) begin
            state_d      = ST_SEARCH;
            delay_d      = '0;
            best_delay_d = '0;
            best_err_d   = '1;
            win_err_d    = '0;
            win_cnt_d    = '0;
            bit_cnt_d    = '0;
            err_cnt_d    = '0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (s_if.ref_valid) begin
                        fill_cnt_d = fill_cnt_q + 1'b1;
                        if (&fill_cnt_q) begin
                            state_d      = ST_SEARCH;
                            delay_d      = '0;
                            best_delay_d = '0;
                            best_err_d   = '1;
                            win_err_d    = '0;
                            win_cnt_d    = '0;
                        end
                    end
                end
                // Ties keep the earlier delay because the update needs a strict improvement.
                ST_SEARCH: begin
                    if (strobe) begin
                        win_cnt_d = win_cnt_q + 1'b1;
                        win_err_d = win_err_sum;
                        if (&win_cnt_q) begin
                            win_err_d = '0;
                            if (win_better) begin
                                best_err_d   = win_err_sum;
                                best_delay_d = delay_q;
                            end
                            if (&delay_q) begin
                                state_d = ST_LOCKED;
                                delay_d = win_better ? delay_q : best_delay_q;
                            end else begin
                                delay_d = delay_q + 1'b1;
                            end
                        end
                    end
                end
                ST_LOCKED: begin
                    if (strobe) begin
                        if (!(&bit_cnt_q)) begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                        if (err_bit && !(&err_cnt_q)) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_q      <= ST_FILL;
            phase_q      <= '0;
            rx_bit_q     <= 1'b0;
            rx_valid_q   <= 1'b0;
            fill_cnt_q   <= '0;
            delay_q      <= '0;
            best_delay_q <= '0;
            best_err_q   <= '1;
            win_err_q    <= '0;
            win_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            err_cnt_q    <= '0;
        end else if (i_enable) begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            rx_bit_q     <= rx_bit_d;
            rx_valid_q   <= rx_valid_d;
            fill_cnt_q   <= fill_cnt_d;
            delay_q      <= delay_d;
            best_delay_q <= best_delay_d;
            best_err_q   <= best_err_d;
            win_err_q    <= win_err_d;
            win_cnt_q    <= win_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign o_rx_bit    = rx_bit_q;
    assign o_rx_valid  = rx_valid_q;
    assign o_locked    = (state_q == ST_LOCKED);
    assign o_delay     = delay_q;
    assign o_bit_count = bit_cnt_q;
    assign o_err_count = err_cnt_q;

endmodule

// File: tb/tb_rx_ber_checker.sv
// Directed bench: PRBS9 reference, RX stream delayed 37 bauds, reduced search geometry
// (64 delays x 32-decision windows) plus a 4-bit-counter copy for saturation.
module tb_rx_ber_checker;

    localparam int NB_DELAY = 6;
    localparam int NB_WIN   = 5;
    localparam int LAT      = 37;
    localparam logic [7:0] POS = 8'h20;
    localparam logic [7:0] NEG = 8'hE0;

    logic       clock = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_enable = 1'b1;
    logic [1:0] i_phase_sel = 2'd2;
    logic       i_resync = 1'b0;

    logic                rx_bit, rx_valid, locked;
    logic [NB_DELAY-1:0] delay;
    logic [63:0]         bit_cnt, err_cnt;
    logic                s_rx_bit, s_rx_valid, s_locked;
    logic [NB_DELAY-1:0] s_delay;
    logic [3:0]          s_bit_cnt, s_err_cnt;

    int   checks = 0;
    int   fails = 0;
    int   n_baud = 0;
    logic [8:0] prbs = 9'h1FF;
    logic hist [0:16383];

    rx_ber_checker_if #(.NB_INPUT(8)) bus ();

    rx_ber_checker #(.NB_INPUT(8), .NB_DELAY(NB_DELAY), .NB_WIN(NB_WIN), .NB_CNT(64)) dut (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .s_if(bus.slave),
        .i_phase_sel(i_phase_sel), .i_resync(i_resync),
        .o_rx_bit(rx_bit), .o_rx_valid(rx_valid), .o_locked(locked), .o_delay(delay),
        .o_bit_count(bit_cnt), .o_err_count(err_cnt)
    );

    rx_ber_checker #(.NB_INPUT(8), .NB_DELAY(NB_DELAY), .NB_WIN(NB_WIN), .NB_CNT(4)) dut_sat (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .s_if(bus.slave),
        .i_phase_sel(i_phase_sel), .i_resync(i_resync),
        .o_rx_bit(s_rx_bit), .o_rx_valid(s_rx_valid), .o_locked(s_locked), .o_delay(s_delay),
        .o_bit_count(s_bit_cnt), .o_err_count(s_err_cnt)
    );

    always #5 clock = ~clock;

    // One clock of stimulus; outputs are stable when this returns.
    task automatic drive_cycle(input logic v, input logic [7:0] smp, input logic rv, input logic rb);
        bus.valid     = v;
        bus.sample    = smp;
        bus.ref_valid = rv;
        bus.ref_bit   = rb;
        @(posedge clock);
        #1;
    endtask

    task automatic next_ref(output logic rb, output logic rx);
        rb = prbs[8] ^ prbs[4];
        prbs = {prbs[7:0], rb};
        hist[n_baud] = rb;
        rx = (n_baud >= LAT) ? hist[n_baud - LAT] : 1'b0;
        n_baud++;
    endtask

    // inv_period 0: clean; N: invert the decision sample of every Nth baud.
    task automatic send_bauds(input int count, input int inv_period);
        logic rb, rx;
        for (int k = 0; k < count; k++) begin
            next_ref(rb, rx);
            if (inv_period != 0 && (k % inv_period) == inv_period - 1) rx = ~rx;
            drive_cycle(1'b1, 8'h00, 1'b1, rb);
            drive_cycle(1'b1, 8'h00, 1'b0, 1'b0);
            drive_cycle(1'b1, rx ? NEG : POS, 1'b0, 1'b0);
            drive_cycle(1'b1, 8'h00, 1'b0, 1'b0);
        end
    endtask

    task automatic pulse_resync();
        i_resync = 1'b1;
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        i_resync = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_resync = 1'b1;
        for (int c = 0; c < 3; c++) drive_cycle(1'b1, NEG, 1'b1, 1'b1);
        i_reset = 1'b0;
        i_resync = 1'b0;
        checks++; if (locked !== 1'b0)   begin fails++; $display("[TB] FAIL reset_locked got %b want 0", locked); end
        checks++; if (delay !== '0)      begin fails++; $display("[TB] FAIL reset_delay got %0d want 0", delay); end
        checks++; if (bit_cnt !== '0)    begin fails++; $display("[TB] FAIL reset_bits got %0d want 0", bit_cnt); end
        checks++; if (err_cnt !== '0)    begin fails++; $display("[TB] FAIL reset_errs got %0d want 0", err_cnt); end
        checks++; if ({rx_valid, rx_bit} !== 2'b00) begin fails++; $display("[TB] FAIL reset_rx got %b want 00", {rx_valid, rx_bit}); end
    endtask

    task automatic test_fill_and_search();
        send_bauds(94, 0);
        checks++; if (delay !== 6'd0) begin fails++; $display("[TB] FAIL fill_first_window got %0d want 0", delay); end
        send_bauds(1, 0);
        checks++; if (delay !== 6'd1) begin fails++; $display("[TB] FAIL fill_second_window got %0d want 1", delay); end
        send_bauds(2110 - 95, 0);
        checks++; if ({locked, delay} !== {1'b0, 6'd63}) begin fails++; $display("[TB] FAIL last_window got lock=%b dly=%0d want 0/63", locked, delay); end
        send_bauds(1, 0);
        checks++; if (locked !== 1'b1)  begin fails++; $display("[TB] FAIL clean_lock got %b want 1", locked); end
        checks++; if (delay !== 6'd37)  begin fails++; $display("[TB] FAIL clean_delay got %0d want 37", delay); end
        checks++; if ({bit_cnt, err_cnt} !== 128'd0) begin fails++; $display("[TB] FAIL lock_counts got %0d/%0d want 0/0", bit_cnt, err_cnt); end
        checks++; if ({s_locked, s_delay} !== {1'b1, 6'd37}) begin fails++; $display("[TB] FAIL sat_lock got %b/%0d want 1/37", s_locked, s_delay); end
    endtask

    task automatic test_slicer();
        logic rb, rx;
        next_ref(rb, rx);
        drive_cycle(1'b1, 8'h00, 1'b1, rb);
        checks++; if (rx_valid !== 1'b0) begin fails++; $display("[TB] FAIL rx_valid_p0 got %b want 0", rx_valid); end
        drive_cycle(1'b1, 8'h00, 1'b0, 1'b0);
        drive_cycle(1'b1, rx ? NEG : POS, 1'b0, 1'b0);
        checks++; if ({rx_valid, rx_bit} !== {1'b1, rx}) begin fails++; $display("[TB] FAIL rx_strobe got %b want %b", {rx_valid, rx_bit}, {1'b1, rx}); end
        checks++; if (s_rx_valid !== 1'b1) begin fails++; $display("[TB] FAIL sat_rx_valid got %b want 1", s_rx_valid); end
        drive_cycle(1'b1, 8'h00, 1'b0, 1'b0);
        checks++; if (rx_valid !== 1'b0) begin fails++; $display("[TB] FAIL rx_valid_pulse got %b want 0", rx_valid); end
        checks++; if ({bit_cnt, err_cnt} !== {64'd1, 64'd0}) begin fails++; $display("[TB] FAIL one_baud got %0d/%0d want 1/0", bit_cnt, err_cnt); end
    endtask

    task automatic test_error_injection();
        send_bauds(1000, 100);
        checks++; if (bit_cnt !== 64'd1001) begin fails++; $display("[TB] FAIL inj_bits got %0d want 1001", bit_cnt); end
        checks++; if (err_cnt !== 64'd10)   begin fails++; $display("[TB] FAIL inj_errs got %0d want 10", err_cnt); end
        checks++; if ({s_bit_cnt, s_err_cnt} !== {4'd15, 4'd10}) begin fails++; $display("[TB] FAIL sat_inj got %0d/%0d want 15/10", s_bit_cnt, s_err_cnt); end
    endtask

    task automatic test_resync_freeze();
        pulse_resync();
        checks++; if ({locked, delay} !== {1'b0, 6'd0}) begin fails++; $display("[TB] FAIL resync_state got %b/%0d want 0/0", locked, delay); end
        checks++; if ({bit_cnt, err_cnt} !== 128'd0) begin fails++; $display("[TB] FAIL resync_counts got %0d/%0d want 0/0", bit_cnt, err_cnt); end
        send_bauds(325, 0);
        checks++; if (delay !== 6'd10) begin fails++; $display("[TB] FAIL pre_freeze got %0d want 10", delay); end
        i_enable = 1'b0;
        for (int c = 0; c < 50; c++) drive_cycle(1'b1, NEG, 1'b1, 1'b1);
        i_enable = 1'b1;
        checks++; if ({locked, delay} !== {1'b0, 6'd10}) begin fails++; $display("[TB] FAIL freeze got %b/%0d want 0/10", locked, delay); end
        checks++; if ({bit_cnt, err_cnt} !== 128'd0) begin fails++; $display("[TB] FAIL freeze_counts got %0d/%0d want 0/0", bit_cnt, err_cnt); end
        send_bauds(2047 - 325, 0);
        checks++; if ({locked, delay} !== {1'b0, 6'd63}) begin fails++; $display("[TB] FAIL relock_last got %b/%0d want 0/63", locked, delay); end
        send_bauds(1, 0);
        checks++; if ({locked, delay} !== {1'b1, 6'd37}) begin fails++; $display("[TB] FAIL relock got %b/%0d want 1/37", locked, delay); end
    endtask

    task automatic test_saturation();
        send_bauds(20, 1);
        checks++; if ({bit_cnt, err_cnt} !== {64'd20, 64'd20}) begin fails++; $display("[TB] FAIL all_err got %0d/%0d want 20/20", bit_cnt, err_cnt); end
        checks++; if ({s_bit_cnt, s_err_cnt} !== {4'd15, 4'd15}) begin fails++; $display("[TB] FAIL saturate got %0d/%0d want 15/15", s_bit_cnt, s_err_cnt); end
    endtask

    task automatic test_wrong_phase();
        logic rb, rx;
        i_phase_sel = 2'd0;
        pulse_resync();
        send_bauds(2047, 0);
        checks++; if (locked !== 1'b0) begin fails++; $display("[TB] FAIL wp_prelock got %b want 0", locked); end
        send_bauds(1, 0);
        checks++; if (locked !== 1'b1) begin fails++; $display("[TB] FAIL wp_lock got %b want 1", locked); end
        checks++; if (bit_cnt !== 64'd0) begin fails++; $display("[TB] FAIL wp_bits0 got %0d want 0", bit_cnt); end
        next_ref(rb, rx);
        drive_cycle(1'b1, 8'h00, 1'b1, rb);
        checks++; if ({rx_valid, rx_bit} !== 2'b10) begin fails++; $display("[TB] FAIL wp_zero_slice got %b want 10", {rx_valid, rx_bit}); end
        checks++; if (bit_cnt !== 64'd1) begin fails++; $display("[TB] FAIL wp_bits1 got %0d want 1", bit_cnt); end
        drive_cycle(1'b1, 8'h00, 1'b0, 1'b0);
        drive_cycle(1'b1, rx ? NEG : POS, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'h00, 1'b0, 1'b0);
        i_phase_sel = 2'd2;
    endtask

    task automatic test_reset_priority();
        i_reset = 1'b1;
        i_resync = 1'b1;
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        i_reset = 1'b0;
        i_resync = 1'b0;
        checks++; if ({locked, delay, bit_cnt} !== '0) begin fails++; $display("[TB] FAIL rst_prio got %b/%0d/%0d want 0/0/0", locked, delay, bit_cnt); end
        send_bauds(40, 0);
        checks++; if ({locked, delay} !== {1'b0, 6'd0}) begin fails++; $display("[TB] FAIL rst_fill got %b/%0d want 0/0", locked, delay); end
    endtask

    initial begin
        bus.valid = 1'b0;
        bus.sample = 8'h00;
        bus.ref_valid = 1'b0;
        bus.ref_bit = 1'b0;
        test_reset();
        test_fill_and_search();
        test_slicer();
        test_error_injection();
        test_resync_freeze();
        test_saturation();
        test_wrong_phase();
        test_reset_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
